lif_neuron_scheduler: RTL and testbench

//   Time-multiplexes one signed 8-bit accumulate/threshold-compare datapath across NUM_NEURONS

---
 rtl/lif_neuron_scheduler_if.sv | 27 ++
 rtl/lif_neuron_scheduler.sv | 192 +++++++++++++++++++
 tb/tb_lif_neuron_scheduler.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/lif_neuron_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module  : lif_neuron_scheduler_if
// Brief   : Event-input and spike-output handshake bundle for the LIF scheduler.
// Revision: 1.0 - initial release
// ============================================================================
interface lif_neuron_scheduler_if #(
    parameter int ID_W = 4
);
    logic                   in_valid;
    logic                   in_ready;
    logic [ID_W-1:0]        in_id;
    logic signed [7:0]      in_weight;
    logic                   spike_valid;
    logic [ID_W-1:0]        spike_id;

    modport master (
        output in_valid, in_id, in_weight,
        input  in_ready, spike_valid, spike_id
    );

    modport slave (
        input  in_valid, in_id, in_weight,
        output in_ready, spike_valid, spike_id
    );
endinterface
`default_nettype wire

// File: rtl/lif_neuron_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : lif_neuron_scheduler
// Brief   : One shared signed 8-bit accumulate/compare datapath serving
//           NUM_NEURONS leaky integrate-and-fire neurons, one timestep at a time.
//           Optional refractory counters: define LIF_REFRACTORY_EN.
// Revision: 1.0 - initial release
// ============================================================================
module lif_neuron_scheduler #(
    parameter int NUM_NEURONS  = 16,
    parameter int ID_W         = 4,
    parameter int REFRAC_STEPS = 2
) (
    input  wire                 clk,
    input  wire                 clear,
    input  wire signed [7:0]    threshold,
    input  wire [6:0]           leak,
    input  wire                 step_start,
    input  wire                 step_end,
    output wire                 step_done,
    output wire                 busy,
    output wire                 id_err,
    lif_neuron_scheduler_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_SCAN  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic signed [7:0]      r_thr;
    logic [6:0]             r_leak;
    logic signed [7:0]      r_pot [NUM_NEURONS];
    logic [ID_W-1:0]        r_scan_idx;
    logic                   r_spike_valid;
    logic [ID_W-1:0]        r_spike_id;
    logic                   r_id_err;

    logic                   w_accept;
    logic                   w_id_in_range;
    logic                   w_scan_last;
    logic                   w_scanning;
    logic signed [7:0]      w_acc_pot;
    logic [8:0]             w_acc_sum9;
    logic signed [7:0]      w_acc_sat;
    logic signed [7:0]      w_scan_pot;
    logic [8:0]             w_mag9;
    logic signed [7:0]      w_leaked;
    logic                   w_fire;
    logic                   w_acc_blocked;
    logic                   w_scan_blocked;

    assign w_accept      = bus.in_valid && (r_state == S_ACCUM);
    assign w_id_in_range = (32'(bus.in_id) < 32'(NUM_NEURONS));
    assign w_scanning    = (r_state == S_SCAN);
    assign w_scan_last   = (r_scan_idx == ID_W'(NUM_NEURONS - 1));

    assign bus.in_ready    = (r_state == S_ACCUM);
    assign bus.spike_valid = r_spike_valid;
    assign bus.spike_id    = r_spike_id;
    assign busy            = (r_state != S_IDLE);
    assign step_done       = (r_state == S_DONE);
    assign id_err          = r_id_err;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (step_start)  w_state_nxt = S_ACCUM;
            S_ACCUM: if (step_end)    w_state_nxt = S_SCAN;
            S_SCAN:  if (w_scan_last) w_state_nxt = S_DONE;
            S_DONE:                   w_state_nxt = S_IDLE;
            default:                  w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Accumulate path: the write lands at the next edge, so a following beat
    // to the same neuron already reads the updated value.
    always_comb begin
        w_acc_pot = '0;
        for (int i = 0; i < NUM_NEURONS; i++) begin
            if (bus.in_id == ID_W'(i)) w_acc_pot = r_pot[i];
        end
    end

    assign w_acc_sum9 = {w_acc_pot[7], w_acc_pot} + {bus.in_weight[7], bus.in_weight};
    assign w_acc_sat  = (w_acc_sum9[8] != w_acc_sum9[7]) ?
                        (w_acc_sum9[8] ? -8'sd128 : 8'sd127) : w_acc_sum9[7:0];

    always_comb begin
        w_scan_pot = '0;
        for (int i = 0; i < NUM_NEURONS; i++) begin
            if (r_scan_idx == ID_W'(i)) w_scan_pot = r_pot[i];
        end
    end

    // Leak pulls toward zero and clamps at zero; |pot| needs 9 bits for -128.
    assign w_mag9   = w_scan_pot[7] ? (9'd0 - {w_scan_pot[7], w_scan_pot}) : {1'b0, w_scan_pot};
    assign w_leaked = ({2'b00, r_leak} >= w_mag9) ? 8'sd0 :
                      (w_scan_pot[7] ? (w_scan_pot + $signed({1'b0, r_leak}))
                                     : (w_scan_pot - $signed({1'b0, r_leak})));
    assign w_fire   = (w_scan_pot >= r_thr) && !w_scan_blocked;

`ifdef LIF_REFRACTORY_EN
    localparam int RC_W = (REFRAC_STEPS < 1) ? 1 : $clog2(REFRAC_STEPS + 1);

    logic [RC_W-1:0] r_refrac [NUM_NEURONS];
    logic [RC_W-1:0] w_refrac_acc;
    logic [RC_W-1:0] w_refrac_scan;

    always_comb begin
        w_refrac_acc  = '0;
        w_refrac_scan = '0;
        for (int i = 0; i < NUM_NEURONS; i++) begin
            if (bus.in_id == ID_W'(i))  w_refrac_acc  = r_refrac[i];
            if (r_scan_idx == ID_W'(i)) w_refrac_scan = r_refrac[i];
        end
    end

    assign w_acc_blocked  = (w_refrac_acc != '0);
    assign w_scan_blocked = (w_refrac_scan != '0);

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            for (int i = 0; i < NUM_NEURONS; i++) r_refrac[i] <= '0;
        end else if (w_scanning) begin
            for (int i = 0; i < NUM_NEURONS; i++) begin
                if (r_scan_idx == ID_W'(i)) begin
                    if (w_fire) begin
                        r_refrac[i] <= RC_W'(REFRAC_STEPS);
                    end else if (r_refrac[i] != '0) begin
                        r_refrac[i] <= r_refrac[i] - RC_W'(1);
                    end
                end
            end
        end
    end
`else
    logic w_unused_refrac;
    assign w_unused_refrac = (REFRAC_STEPS != 0);
    assign w_acc_blocked   = 1'b0;
    assign w_scan_blocked  = 1'b0;
`endif

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            for (int i = 0; i < NUM_NEURONS; i++) r_pot[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_NEURONS; i++) begin
                if (w_scanning && (r_scan_idx == ID_W'(i))) begin
                    r_pot[i] <= w_fire ? 8'sd0 : w_leaked;
                end else if (w_accept && w_id_in_range && !w_acc_blocked &&
                             (bus.in_id == ID_W'(i))) begin
                    r_pot[i] <= w_acc_sat;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            r_thr         <= '0;
            r_leak        <= '0;
            r_scan_idx    <= '0;
            r_spike_valid <= 1'b0;
            r_spike_id    <= '0;
            r_id_err      <= 1'b0;
        end else begin
            if ((r_state == S_IDLE) && step_start) begin
                r_thr  <= threshold;
                r_leak <= leak;
            end
            r_scan_idx    <= w_scanning ? (r_scan_idx + ID_W'(1)) : '0;
            r_spike_valid <= w_scanning && w_fire;
            r_spike_id    <= (w_scanning && w_fire) ? r_scan_idx : '0;
            if (w_accept && !w_id_in_range) r_id_err <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lif_neuron_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : tb_lif_neuron_scheduler
// Brief   : Randomized and directed bench for lif_neuron_scheduler against a
//           timestep-level behavioural model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_lif_neuron_scheduler;
    localparam int N   = 12;
    localparam int IDW = 4;
`ifdef LIF_REFRACTORY_EN
    localparam int REFR = 2;
`else
    localparam int REFR = 0;
`endif

    logic clk = 1'b0;
    logic clear;
    logic signed [7:0] threshold;
    logic [6:0] leak;
    logic step_start, step_end;
    wire  step_done, busy, id_err;

    always #5 clk = ~clk;

    lif_neuron_scheduler_if #(.ID_W(IDW)) bus ();

    lif_neuron_scheduler #(
        .NUM_NEURONS (N),
        .ID_W        (IDW),
        .REFRAC_STEPS(2)
    ) dut (
        .clk       (clk),
        .clear     (clear),
        .threshold (threshold),
        .leak      (leak),
        .step_start(step_start),
        .step_end  (step_end),
        .step_done (step_done),
        .busy      (busy),
        .id_err    (id_err),
        .bus       (bus.slave)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: actual %0d required %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Behavioural model: whole-timestep semantics.
    int     mpot [N];
    int     mref [N];
    bit     merr;
    bit [N-1:0] exp_spk;
    int     ev_id [$];
    int     ev_w  [$];

    function automatic int sat8(input int v);
        return (v > 127) ? 127 : ((v < -128) ? -128 : v);
    endfunction

    function automatic int toward_zero(input int p, input int l);
        if (p > 0) return (p > l) ? p - l : 0;
        if (p < 0) return (-p > l) ? p + l : 0;
        return 0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin mpot[i] = 0; mref[i] = 0; end
        merr = 1'b0;
    endtask

    task automatic model_step(input int thr, input int lk);
        foreach (ev_id[i]) begin
            if (ev_id[i] >= N) merr = 1'b1;
            else if (mref[ev_id[i]] == 0) mpot[ev_id[i]] = sat8(mpot[ev_id[i]] + ev_w[i]);
        end
        exp_spk = '0;
        for (int k = 0; k < N; k++) begin
            if (mref[k] == 0 && mpot[k] >= thr) begin
                exp_spk[k] = 1'b1;
                mpot[k]    = 0;
                mref[k]    = REFR;
            end else begin
                mpot[k] = toward_zero(mpot[k], lk);
                if (mref[k] > 0) mref[k]--;
            end
        end
    endtask

    // Cycle-level compare process.
    int         cycle_cnt = 0;
    int         scan_t0   = 0;
    bit         scan_active = 1'b0;
    bit [N-1:0] obs_mask;

    always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

    always @(negedge clk) begin
        if (!clear) begin
            if (scan_active) begin
                int rel;
                bit ev;
                rel = cycle_cnt - scan_t0;
                if (rel == 0) obs_mask = '0;
                ev = (rel >= 1 && rel <= N) ? exp_spk[rel-1] : 1'b0;
                check("spike_valid", int'(bus.spike_valid), int'(ev));
                if (ev) check("spike_id", int'(bus.spike_id), rel - 1);
                if (bus.spike_valid && bus.spike_id < N) obs_mask[bus.spike_id] = 1'b1;
                check("step_done", int'(step_done), int'(rel == N));
                check("busy_scan", int'(busy), int'(rel <= N));
                check("in_ready_scan", int'(bus.in_ready), 0);
            end else begin
                check("spike_idle", int'(bus.spike_valid), 0);
                check("step_done_idle", int'(step_done), 0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_step(input int thr, input int lk, input bit poke);
        int a;
        model_step(thr, lk);
        threshold  = 8'(thr);
        leak       = 7'(lk);
        step_start = 1'b1;
        tick();
        step_start = 1'b0;
        check("accum_ready", int'(bus.in_ready), 1);
        if (ev_id.size() == 0) begin
            step_end = 1'b1;
            tick();
        end else begin
            for (int i = 0; i < ev_id.size(); i++) begin
                bus.in_valid  = 1'b1;
                bus.in_id     = 4'(ev_id[i]);
                bus.in_weight = 8'(ev_w[i]);
                step_end      = (i == ev_id.size() - 1);
                step_start    = poke;
                tick();
            end
        end
        bus.in_valid = 1'b0;
        step_end     = 1'b0;
        step_start   = 1'b0;
        scan_t0      = cycle_cnt;
        scan_active  = 1'b1;
        for (int j = 0; j <= N; j++) begin
            step_start = poke & 1'($urandom_range(0, 1));
            tick();
        end
        step_start = 1'b0;
        @(negedge clk);
        #1;
        scan_active = 1'b0;
        check("spike_mask", int'(obs_mask), int'(exp_spk));
        for (int k = 0; k < N; k++) begin
            a = dut.r_pot[k];
            check("pot", a, mpot[k]);
        end
        check("id_err", int'(id_err), int'(merr));
        ev_id.delete();
        ev_w.delete();
    endtask

    task automatic add_ev(input int id, input int w);
        ev_id.push_back(id);
        ev_w.push_back(w);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: bench exceeded its time limit");
        $fatal(1);
    end

    initial begin
        int a;
        clear = 1'b1;
        threshold = '0; leak = '0; step_start = 1'b0; step_end = 1'b0;
        bus.in_valid = 1'b0; bus.in_id = '0; bus.in_weight = '0;
        model_reset();
        tick(); tick();
        clear = 1'b0;
        tick();
        check("rst_busy", int'(busy), 0);
        check("rst_ready", int'(bus.in_ready), 0);
        check("rst_spike", int'(bus.spike_valid), 0);
        check("rst_done", int'(step_done), 0);
        check("rst_id_err", int'(id_err), 0);

        // Clear in the middle of the accumulate phase.
        threshold = 8'sd20; leak = 7'd0; step_start = 1'b1;
        tick();
        step_start = 1'b0;
        bus.in_valid = 1'b1; bus.in_id = 4'd3; bus.in_weight = 8'sd50;
        tick();
        bus.in_valid = 1'b0;
        a = dut.r_pot[3];
        check("t1_pot3_pre", a, 50);
        check("t1_busy_pre", int'(busy), 1);
        #2 clear = 1'b1;
        #1;
        check("t1_busy_clr", int'(busy), 0);
        check("t1_ready_clr", int'(bus.in_ready), 0);
        a = dut.r_pot[3];
        check("t1_pot3_clr", a, 0);
        tick();
        clear = 1'b0;
        model_reset();
        tick();
        run_step(1, 0, 1'b0);
        check("t1_no_spikes", int'(obs_mask), 0);

        // Fire and leak.
        add_ev(2, 12); add_ev(5, 7);
        run_step(10, 2, 1'b0);
        check("t2_mask", int'(obs_mask), 1 << 2);
        a = dut.r_pot[5];
        check("t2_pot5", a, 5);

        // Saturation both ways.
        repeat (5) add_ev(0, 100);
        add_ev(1, -100); add_ev(1, -100);
        run_step(127, 3, 1'b0);
        check("t3_mask", int'(obs_mask), 1);
        a = dut.r_pot[1];
        check("t3_pot1", a, -125);

        // Back-to-back beats to one neuron.
        repeat (4) add_ev(7, 5);
        run_step(20, 0, 1'b0);
        check("t4_mask", int'(obs_mask), 1 << 7);

        // Out-of-range id, ignored step_start, beat carried with step_end.
        add_ev(N, 9); add_ev(3, 4);
        run_step(100, 0, 1'b1);
        check("t5_id_err", int'(id_err), 1);
        a = dut.r_pot[3];
        check("t5_pot3", a, 4);

`ifdef LIF_REFRACTORY_EN
        for (int s = 0; s < 4; s++) begin
            add_ev(4, 100);
            run_step(50, 0, 1'b0);
            check("t6_mask", int'(obs_mask), (s == 0 || s == 3) ? (1 << 4) : 0);
        end
`endif

        for (int s = 0; s < 40; s++) begin
            int ne;
            ne = int'($urandom_range(0, 8));
            for (int e = 0; e < ne; e++) begin
                add_ev(int'($urandom_range(0, 15)), int'($urandom_range(0, 255)) - 128);
            end
            run_step(int'($urandom_range(0, 120)) - 20, int'($urandom_range(0, 20)),
                     1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
`default_nettype wire
